// File: rtl/noc_pkg.sv
// noc_pkg: shared constants and types for the node link blocks.
//   FLIT_W              default flit width in bits
//   DEFAULT_DEPTH       default ingress buffer depth
//   DEFAULT_FULL_MARGIN default free entries kept back after backpressure rises
//   flit_t              one flit at the default width
package noc_pkg;

    localparam int FLIT_W              = 16;
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_FULL_MARGIN = 1;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/link_fifo.sv
// link_fifo: DEPTH-entry FIFO storage with wrapping pointers and an entry count.
// DEPTH need not be a power of two.
//   clk, rst_n  clock, async active-low reset (pointers and count only)
//   push, wdata write wdata at the tail this cycle
//   pop         retire the head entry this cycle
//   rdata       head entry, all-zeros while empty
//   count       stored-entry count
// The caller guarantees no push when full without a same-cycle pop and no
// pop when empty.
module link_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is never cleared; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // When full, a same-cycle push lands on the head slot; the head is read
    // combinationally before that edge, so the popped flit is not disturbed.
    assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/node_link_adapter.sv
// node_link_adapter: ingress FIFO between an upstream and downstream flat link.
//   clk, rst_n       clock, async active-low reset
//   receiving_data   upstream flit valid
//   data_in          upstream flit
//   buffer_full_out  registered backpressure to upstream
//   sending_data     downstream flit valid (combinational)
//   data_out         head flit, zero while empty
//   buffer_full_in   downstream backpressure; only gates popping
//   occupancy        stored-entry count
//   overflow         sticky: a flit was dropped on a full buffer
module node_link_adapter
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH  = FLIT_W,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int FULL_MARGIN = DEFAULT_FULL_MARGIN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       receiving_data,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic                       buffer_full_out,
    output logic                       sending_data,
    output logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       buffer_full_in,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(DEPTH - FULL_MARGIN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
        $error("node_link_adapter: DEPTH must be 2..64");
    end
    if (FULL_MARGIN < 0 || FULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("node_link_adapter: FULL_MARGIN must be 0..DEPTH-1");
    end

    logic             push;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] occ_next;

    // Pop whenever something is stored and downstream is not stalling.
    assign pop          = (occupancy != '0) && !buffer_full_in;
    assign sending_data = pop;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign push         = receiving_data && ((occupancy < DEPTH_C) || pop);
    assign drop         = receiving_data && !push;

    always_comb begin
        occ_next = occupancy;
        if (push && !pop)      occ_next = occupancy + CNT_ONE;
        else if (pop && !push) occ_next = occupancy - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer_full_out <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            buffer_full_out <= (occ_next >= THRESH_C);
            if (drop) overflow <= 1'b1;
        end
    end

    link_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (data_out),
        .count (occupancy)
    );

endmodule
